uram_port_arbiter: RTL and testbench
====================================

Name: uram_port_arbiter

Overview:
- Shares one port of a dual-port UltraRAM (`uram`) among N requesters.
- Round-robin grant per cycle, valid/ready request handshake, read-response routing through a latency-matched tag pipeline.
- Optional post-reset memory clear sequence.
- Sits between compute engines and one URAM port; instantiate two for ports A and B.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- AWIDTH, 12, address width (matches uram)
- DWIDTH, 32, data width (matches uram)
- RD_LAT, 2, URAM read latency in cycles from registered mem_en to valid mem_dout (1 array + NBPIPE)
- INIT_ON_RESET, 1, 1 = zero every address after reset before accepting requests

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant; handshake when valid&ready
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*AWIDTH  packed addresses, requester i at [i*AWIDTH +: AWIDTH]
- req_wdata  in  N_REQ*DWIDTH  packed write data
- rsp_valid  out  N_REQ  one-hot read-data valid
- rsp_rdata  out  DWIDTH  read data, shared, qualified by rsp_valid
- init_done  out  1  high once clear sequence finished (or immediately if INIT_ON_RESET=0)
- mem_en  out  1  to uram mem_en
- mem_we  out  1  to uram we
- mem_addr  out  AWIDTH  to uram addr
- mem_din  out  DWIDTH  to uram din
- mem_dout  in  DWIDTH  from uram dout

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
  - init_done=0 if INIT_ON_RESET=1, else 1.
  - RR pointer=0.
  - Tag pipeline cleared; in-flight reads are discarded, no response issued.
- FSM states:
  - INIT (entered on reset if INIT_ON_RESET=1):
    - Writes 0 to addresses 0..2^AWIDTH-1, one per cycle: mem_en=1, mem_we=1.
    - After the last address: init_done=1, go to ARB.
    - req_ready=0 throughout.
    - Address counter AWIDTH+1 bits; terminal count at 2^AWIDTH-1.
  - ARB: serves requests indefinitely. No other transitions except reset.
- Arbitration (ARB):
  - Combinational, each cycle.
  - Highest priority is requester at RR pointer, then ascending index with wrap.
  - req_ready is one-hot or zero: asserted only for the selected requester whose req_valid=1; never asserted without valid.
  - After a grant to i, pointer = (i+1) mod N_REQ; pointer unchanged on idle cycles.
  - Single active requester is granted every cycle (full throughput); no bubbles between back-to-back grants.
- Issue:
  - On handshake at cycle t, mem_en/mem_we/mem_addr/mem_din are registered and presented at t+1.
  - mem_en=0 on cycles with no grant.
  - Write completes with no response.
- Read response:
  - Tag (one-hot grantee, valid) shifts through a RD_LAT+1 stage pipeline.
  - rsp_valid[i]=1 exactly at cycle t+1+RD_LAT.
  - rsp_rdata=mem_dout combinationally, same cycle.
  - Back-to-back reads give back-to-back responses in issue order.
- No backpressure on responses: requesters must always accept rsp_valid.
- Same-cycle read and write to the same address by different requesters is impossible (single grant). Read-after-write ordering is preserved by issue order.
- Reset asserted mid-operation (INIT or ARB): immediate return to reset values. INIT restarts from address 0.

Optional Feature:
- URAM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, requester 0 highest, descending by index; RR pointer removed. Lower requesters can starve by design.
  - Undefined (default): round-robin as above.

Decomposition:
- Package uram_arb_pkg holds:
  - State enum typedef (ST_INIT, ST_ARB).
  - Tag struct typedef {logic vld; logic [N_REQ-1:0] who}.
  - Function for rotate-and-priority-encode used by the arbiter.
- One natural sub-module: rr_arbiter, the combinational grant plus pointer register, reusable elsewhere.
- Tag pipeline and INIT FSM stay in the top module.

Test Plan:
1. INIT_ON_RESET=1, AWIDTH=4: release rst_n → 16 consecutive zero writes at addr 0..15, then init_done=1; req_ready stays 0 until then.
2. N_REQ=4, all req_valid=1 continuously after init → grants cycle 0,1,2,3,0,…, one per cycle, each exactly one-hot.
3. Requester 2 writes 0xDEADBEEF to addr 0x5, next cycle reads 0x5 → rsp_valid[2] at handshake+3 (RD_LAT=2) with rsp_rdata=0xDEADBEEF.
4. Requesters 1 and 3 issue interleaved reads to addr 1 and 3 (preloaded 0x11, 0x33) → rsp_valid pulses 0x2 then 0x8 on consecutive cycles, data 0x11 then 0x33.
5. Assert rst_n low with 2 reads in flight → no rsp_valid after reset release; pointer back to 0; INIT reruns.
6. With URAM_ARB_FIXED_PRIO_EN, requesters 0 and 3 always valid → requester 0 granted every cycle, 3 never.

Source files
------------

// File: rtl/uram_arb_pkg.sv
// uram_arb_pkg: shared types and the rotate-and-priority-encode helper for the URAM port arbiter
package uram_arb_pkg;
  localparam int MAX_REQ = 8;
  typedef enum logic {ST_INIT, ST_ARB} state_t;
  typedef struct packed {
    logic               vld;
    logic [MAX_REQ-1:0] who;
  } tag_t;
  // One-hot pick of the first set request at or after ptr, wrapping within the first n requesters.
  // Walking k downwards lets the k=0 candidate (ptr itself) win last, so it has top priority.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr, input int n);
    logic [MAX_REQ-1:0] g;
    int idx;
    g = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx -= n;
      if (k < n && req[idx[2:0]]) g = MAX_REQ'(1) << idx[2:0];
    end
    return g;
  endfunction
endpackage

// File: rtl/uram_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot grant with round-robin pointer; URAM_ARB_FIXED_PRIO_EN selects fixed priority (0 highest)
module rr_arbiter
  import uram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
`ifdef URAM_ARB_FIXED_PRIO_EN
  logic unused_clk;
  assign unused_clk = clk ^ rst_n;
  // Lowest index wins; higher indices may starve
  always_comb grant = en ? N'(rr_pick(MAX_REQ'(req), 3'd0, N)) : '0;
`else
  logic [2:0] ptr;
  // Requester at ptr first, then ascending with wrap
  always_comb grant = en ? N'(rr_pick(MAX_REQ'(req), ptr, N)) : '0;
  // Pointer moves just past the winner; idle cycles leave it alone
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else for (int i = 0; i < N; i++) if (grant[i]) ptr <= (i == N - 1) ? 3'd0 : 3'(i + 1);
`endif
endmodule

// File: rtl/uram_port_arbiter.sv
// uram_port_arbiter: shares one URAM port among N_REQ requesters with optional post-reset clear; URAM_ARB_FIXED_PRIO_EN picks fixed priority
module uram_port_arbiter
  import uram_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int AWIDTH        = 12,
  parameter int DWIDTH        = 32,
  parameter int RD_LAT        = 2,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*AWIDTH-1:0] req_addr,
  input  logic [N_REQ*DWIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]       rsp_rdata,
  output logic                    init_done,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [AWIDTH-1:0]       mem_addr,
  output logic [DWIDTH-1:0]       mem_din,
  input  logic [DWIDTH-1:0]       mem_dout
);
  localparam logic [AWIDTH:0] LAST = (AWIDTH + 1)'((2 ** AWIDTH) - 1);
  state_t             state;
  logic [AWIDTH:0]    cnt;
  logic [N_REQ-1:0]   grant;
  logic               sel_we;
  logic [AWIDTH-1:0]  sel_addr;
  logic [DWIDTH-1:0]  sel_din;
  tag_t               pipe [RD_LAT+1];
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == ST_ARB),
    .req  (req_valid),
    .grant(grant)
  );
  assign req_ready = grant;
  assign rsp_valid = pipe[RD_LAT].vld ? N_REQ'(pipe[RD_LAT].who) : '0;
  assign rsp_rdata = mem_dout;
  // Mux the granted requester's command; grant is one-hot so OR-ing is exact
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_we   |= grant[i] & req_we[i];
      sel_addr |= grant[i] ? req_addr[i*AWIDTH +: AWIDTH] : '0;
      sel_din  |= grant[i] ? req_wdata[i*DWIDTH +: DWIDTH] : '0;
    end
  end
  // Clear sequence then registered issue of the granted command
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_ARB;
      init_done <= (INIT_ON_RESET == 0);
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else if (state == ST_INIT) begin
      mem_en   <= 1'b1;
      mem_we   <= 1'b1;
      mem_addr <= AWIDTH'(cnt);
      mem_din  <= '0;
      cnt      <= cnt + 1'b1;
      if (cnt == LAST) begin
        state     <= ST_ARB;
        init_done <= 1'b1;
      end
    end else begin
      mem_en   <= |grant;
      mem_we   <= sel_we;
      mem_addr <= sel_addr;
      mem_din  <= sel_din;
    end
  // Read tags ride alongside the URAM latency so the response lands on the right requester
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k <= RD_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= '{vld: (|grant) & ~sel_we, who: MAX_REQ'(grant)};
      for (int k = 1; k <= RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
endmodule

// File: tb/tb_uram_port_arbiter.sv
// tb_uram_port_arbiter: table vectors plus directed sequences with a response scoreboard
module tb_uram_port_arbiter;
  localparam int N = 4, AW = 4, DW = 32;
`ifdef URAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, mem_din, mem_dout;
  logic init_done, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0] d0_ready, d0_rsp_valid;
  logic [DW-1:0] d0_rdata, d0_din;
  logic d0_init_done, d0_en, d0_we;
  logic [AW-1:0] d0_addr;
  uram_port_arbiter #(.N_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .RD_LAT(2), .INIT_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );
  uram_port_arbiter #(.N_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .RD_LAT(2), .INIT_ON_RESET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid('0), .req_ready(d0_ready), .req_we('0),
    .req_addr('0), .req_wdata('0), .rsp_valid(d0_rsp_valid), .rsp_rdata(d0_rdata),
    .init_done(d0_init_done), .mem_en(d0_en), .mem_we(d0_we), .mem_addr(d0_addr),
    .mem_din(d0_din), .mem_dout('0)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [N-1:0]  exp;
  } vec_t;
  typedef struct {
    int            cyc;
    logic [N-1:0]  who;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rd1, rd2;
  int cyc = 0, n_cmp = 0, n_fail = 0;
  assign mem_dout = rd2;
  // URAM model: one array stage plus one output register
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      rd1 <= mem[mem_addr];
    end
    rd2 <= rd1;
    cyc <= cyc + 1;
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  function automatic logic [N-1:0] fp(input logic [N-1:0] v);
    return v & (~v + 1'b1);
  endfunction
  // Scoreboard: reads push an expected response due three cycles after the handshake
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      check("rsp_valid", 64'(rsp_valid), 64'(sb[0].who));
      check("rsp_rdata", 64'(rsp_rdata), 64'(sb[0].data));
      void'(sb.pop_front());
    end else if (rsp_valid != '0) check("rsp_spurious", 64'(rsp_valid), 64'(0));
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) begin
        if (req_we[i]) shadow[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
        else sb.push_back('{cyc: cyc + 3, who: N'(1 << i), data: shadow[req_addr[i*AW +: AW]]});
      end
  end
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output logic [N-1:0] rdy);
    req_valid = v;
    req_we    = w;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = a + AW'(i);
      req_wdata[i*DW +: DW] = d + DW'(i);
    end
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1;
  endtask
  task automatic run_init();
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    req_valid = '1;
    req_we    = '0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("init_rel_ready", 64'(req_ready), 64'(0));
    check("init_rel_done", 64'(init_done), 64'(0));
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 15) req_valid = '0;
      @(negedge clk);
      check("init_write", 64'({mem_en, mem_we, mem_addr, mem_din, init_done}),
            64'({1'b1, 1'b1, AW'(i), 32'h0, i == 15}));
      check("init_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl [11];
    logic [N-1:0] rdy;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1 rst_n = 1'b0;
    tbl[0]  = '{4'b0000, 4'b0000, 4'd8, 32'hA0, 4'b0000};
    tbl[1]  = '{4'b0110, 4'b0000, 4'd8, 32'hA0, 4'b0010};
    tbl[2]  = '{4'b0110, 4'b0000, 4'd8, 32'hA0, 4'b0100};
    tbl[3]  = '{4'b0011, 4'b0000, 4'd8, 32'hA0, 4'b0001};
    tbl[4]  = '{4'b1001, 4'b0000, 4'd8, 32'hA0, 4'b1000};
    tbl[5]  = '{4'b1000, 4'b0000, 4'd8, 32'hA0, 4'b1000};
    tbl[6]  = '{4'b1000, 4'b0000, 4'd8, 32'hA0, 4'b1000};
    tbl[7]  = '{4'b0000, 4'b0000, 4'd8, 32'hA0, 4'b0000};
    tbl[8]  = '{4'b1111, 4'b1111, 4'd8, 32'hA0, 4'b0001};
    tbl[9]  = '{4'b1100, 4'b0000, 4'd8, 32'hA0, 4'b0100};
    tbl[10] = '{4'b0101, 4'b0000, 4'd8, 32'hA0, 4'b0001};
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rsp", 64'(rsp_valid), 64'(0));
    check("rst_mem", 64'({mem_en, mem_we, mem_addr, mem_din}), 64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));
    check("rst_noinit_done", 64'(d0_init_done), 64'(1));
    check("rst_noinit_en", 64'(d0_en), 64'(0));
    @(posedge clk);
    #1;
    run_init();
    for (int i = 0; i < 8; i++) begin
      step(FIXED ? 4'b1001 : 4'b1111, 4'b0000, 4'd0, 32'h0, rdy);
      check("all_valid_grant", 64'(rdy), FIXED ? 64'(1) : 64'(1 << (i % 4)));
    end
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, rdy);
      check($sformatf("vec%0d_grant", i), 64'(rdy), 64'(FIXED ? fp(tbl[i].v) : tbl[i].exp));
    end
    step(4'b0100, 4'b0100, 4'd3, 32'hDEADBEED, rdy);
    check("raw_wr_grant", 64'(rdy), 64'(4'b0100));
    step(4'b0100, 4'b0000, 4'd3, 32'h0, rdy);
    check("raw_rd_grant", 64'(rdy), 64'(4'b0100));
    repeat (2) step(4'b0000, 4'b0000, 4'd0, 32'h0, rdy);
    @(negedge clk);
    check("raw_rsp", 64'({rsp_valid, rsp_rdata}), 64'({4'b0100, 32'hDEADBEEF}));
    @(posedge clk);
    #1;
    step(4'b0010, 4'b0010, 4'd0, 32'h10, rdy);
    step(4'b1000, 4'b1000, 4'd0, 32'h30, rdy);
    step(4'b0010, 4'b0000, 4'd0, 32'h0, rdy);
    step(4'b1000, 4'b0000, 4'd0, 32'h0, rdy);
    step(4'b0000, 4'b0000, 4'd0, 32'h0, rdy);
    @(negedge clk);
    check("interleave_rsp1", 64'({rsp_valid, rsp_rdata}), 64'({4'b0010, 32'h11}));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("interleave_rsp3", 64'({rsp_valid, rsp_rdata}), 64'({4'b1000, 32'h33}));
    @(posedge clk);
    #1;
    step(4'b0010, 4'b0000, 4'd0, 32'h0, rdy);
    step(4'b0100, 4'b0000, 4'd0, 32'h0, rdy);
    rst_n = 1'b0;
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      check("midrst_quiet", 64'({rsp_valid, mem_en, init_done}), 64'(0));
      @(posedge clk);
      #1;
    end
    run_init();
    step(4'b1111, 4'b0000, 4'd0, 32'h0, rdy);
    check("post_rst_ptr", 64'(rdy), 64'(4'b0001));
    step(4'b1111, 4'b0000, 4'd0, 32'h0, rdy);
    check("post_rst_next", 64'(rdy), FIXED ? 64'(4'b0001) : 64'(4'b0010));
    repeat (5) step(4'b0000, 4'b0000, 4'd0, 32'h0, rdy);
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
